// File: rtl/data_sram_slave.sv
// Data SRAM responder: word-wide synchronous RAM plus a small MMIO window (LED, TIMER, SCRATCH).
// Optional free-running timer enabled with `define DATA_SRAM_SLAVE_TIMER_EN.
module data_sram_slave #(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [15:0] MMIO_BASE  = 16'hBFAF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_data_sram_we,
    input  logic [31:0] io_data_sram_addr,
    input  logic [31:0] io_data_sram_wdata,
    output logic [31:0] io_data_sram_rdata,
    output logic [15:0] io_led,
    output logic [31:0] io_timer
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // MMIO word offsets (byte offset >> 2)
    localparam logic [13:0] OFF_LED     = 14'h0000;
    localparam logic [13:0] OFF_TIMER   = 14'h0001;
    localparam logic [13:0] OFF_SCRATCH = 14'h0002;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_MMIO = 2'd2
    } rd_sel_e;

    logic [31:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [13:0]           mmio_off;
    logic                  is_mmio;
    logic                  wr_ok;
    logic                  ram_we;
    logic                  mmio_we;

    rd_sel_e     rd_sel_d, rd_sel_q;
    logic [31:0] ram_rd_q;
    logic [31:0] mmio_rd_d, mmio_rd_q;
    logic [15:0] led_d, led_q;
    logic [31:0] scratch_d, scratch_q;
    logic [31:0] timer_d, timer_q;

    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, io_data_sram_addr[1:0]};

    always_comb begin
        is_mmio  = (io_data_sram_addr[31:16] == MMIO_BASE);
        ram_idx  = io_data_sram_addr[ADDR_WIDTH+1:2];
        mmio_off = io_data_sram_addr[15:2];
        // writes presented during reset are dropped everywhere
        wr_ok    = io_data_sram_we & ~reset;
        ram_we   = wr_ok & ~is_mmio;
        mmio_we  = wr_ok & is_mmio;
    end

    always_comb begin
        led_d     = led_q;
        scratch_d = scratch_q;
        mmio_rd_d = 32'h0;
`ifdef DATA_SRAM_SLAVE_TIMER_EN
        timer_d   = timer_q + 32'd1;
`else
        timer_d   = 32'h0;
`endif
        case (mmio_off)
            OFF_LED: begin
                mmio_rd_d = {16'h0, led_q};
                if (mmio_we) led_d = io_data_sram_wdata[15:0];
            end
`ifdef DATA_SRAM_SLAVE_TIMER_EN
            OFF_TIMER: begin
                mmio_rd_d = timer_q;
                if (mmio_we) timer_d = io_data_sram_wdata;
            end
`endif
            OFF_SCRATCH: begin
                mmio_rd_d = scratch_q;
                if (mmio_we) scratch_d = io_data_sram_wdata;
            end
            default: mmio_rd_d = 32'h0;
        endcase
    end

    always_comb begin
        rd_sel_d = is_mmio ? SEL_MMIO : SEL_RAM;
    end

    // RAM array and its read register carry no reset so they map onto block RAM
    always_ff @(posedge clock) begin
        if (ram_we) mem[ram_idx] <= io_data_sram_wdata;
        ram_rd_q <= mem[ram_idx];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_sel_q  <= SEL_ZERO;
            mmio_rd_q <= 32'h0;
            led_q     <= 16'h0;
            scratch_q <= 32'h0;
            timer_q   <= 32'h0;
        end else begin
            rd_sel_q  <= rd_sel_d;
            mmio_rd_q <= mmio_rd_d;
            led_q     <= led_d;
            scratch_q <= scratch_d;
            timer_q   <= timer_d;
        end
    end

    always_comb begin
        case (rd_sel_q)
            SEL_RAM:  io_data_sram_rdata = ram_rd_q;
            SEL_MMIO: io_data_sram_rdata = mmio_rd_q;
            default:  io_data_sram_rdata = 32'h0;
        endcase
        io_led   = led_q;
        io_timer = timer_q;
    end

endmodule

// File: tb/tb_data_sram_slave.sv
// Directed, table-driven bench for data_sram_slave plus hand sequences for timer and reset.
module tb_data_sram_slave;

    logic        clock = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [31:0] timer;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    data_sram_slave #(.ADDR_WIDTH(14), .MMIO_BASE(16'hBFAF)) dut (
        .clock              (clock),
        .reset              (reset),
        .io_data_sram_we    (we),
        .io_data_sram_addr  (addr),
        .io_data_sram_wdata (wdata),
        .io_data_sram_rdata (rdata),
        .io_led             (led),
        .io_timer           (timer)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rd;
        logic [15:0] exp_led;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        we = w; addr = a; wdata = d;
    endtask

    initial begin
        //        we    addr           wdata          chk   exp_rd         exp_led
        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0,         16'h0000};
        vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h0000};
        vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1,         1'b0, 32'h0,         16'h0000};
        vecs[3]  = '{1'b1, 32'h0000_0040, 32'h2,         1'b1, 32'h1,         16'h0000};
        vecs[4]  = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h2,         16'h0000};
        vecs[5]  = '{1'b1, 32'h0001_0004, 32'h55,        1'b0, 32'h0,         16'h0000};
        vecs[6]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h55,        16'h0000};
        vecs[7]  = '{1'b1, 32'hBFAF_0000, 32'hFFFF_00A5, 1'b1, 32'h0,         16'h00A5};
        vecs[8]  = '{1'b0, 32'hBFAF_0000, 32'h0,         1'b1, 32'h0000_00A5, 16'h00A5};
        vecs[9]  = '{1'b0, 32'hBFAF_0010, 32'h0,         1'b1, 32'h0,         16'h00A5};
        vecs[10] = '{1'b1, 32'hBFAF_0010, 32'h99,        1'b1, 32'h0,         16'h00A5};
        vecs[11] = '{1'b0, 32'hBFAF_0010, 32'h0,         1'b1, 32'h0,         16'h00A5};
        vecs[12] = '{1'b1, 32'hBFAF_0008, 32'hCAFE_F00D, 1'b1, 32'h0,         16'h00A5};
        vecs[13] = '{1'b1, 32'hBFAF_0008, 32'h1111_1111, 1'b1, 32'hCAFE_F00D, 16'h00A5};
        vecs[14] = '{1'b0, 32'hBFAF_0008, 32'h0,         1'b1, 32'h1111_1111, 16'h00A5};
        vecs[15] = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h00A5};
        vecs[16] = '{1'b0, 32'hBFAF_0000, 32'h0,         1'b1, 32'h0000_00A5, 16'h00A5};
        vecs[17] = '{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h2,         16'h00A5};
        vecs[18] = '{1'b1, 32'hBFAE_0008, 32'h77,        1'b0, 32'h0,         16'h00A5};
        vecs[19] = '{1'b0, 32'h0000_0008, 32'h0,         1'b1, 32'h77,        16'h00A5};

        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step();
        step();
        chk32("reset_rdata", rdata, 32'h0);
        chk32("reset_led", {16'h0, led}, 32'h0);
        chk32("reset_timer", timer, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            step();
            if (vecs[i].chk) chk32($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
            chk32($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
        end

        // timer load and wrap
        drive(1'b1, 32'hBFAF_0004, 32'hFFFF_FFFE);
        step();
`ifdef DATA_SRAM_SLAVE_TIMER_EN
        chk32("timer_load", timer, 32'hFFFF_FFFE);
        drive(1'b0, 32'hBFAF_0004, 32'h0);
        step();
        chk32("timer_inc", timer, 32'hFFFF_FFFF);
        chk32("timer_rd0", rdata, 32'hFFFF_FFFE);
        step();
        chk32("timer_wrap", timer, 32'h0);
        chk32("timer_rd1", rdata, 32'hFFFF_FFFF);
`else
        chk32("timer_off_load", timer, 32'h0);
        drive(1'b0, 32'hBFAF_0004, 32'h0);
        step();
        chk32("timer_off_rd", rdata, 32'h0);
        chk32("timer_off_out", timer, 32'h0);
`endif

        // reset mid-stream: in-flight read dropped, writes during reset ignored
        drive(1'b0, 32'h0000_0100, 32'h0);
        step();
        chk32("pre_reset_rd", rdata, 32'hDEAD_BEEF);
        reset = 1'b1;
        drive(1'b1, 32'h0000_0100, 32'h0);
        step();
        chk32("rst_rdata", rdata, 32'h0);
        chk32("rst_led", {16'h0, led}, 32'h0);
        chk32("rst_timer", timer, 32'h0);
        drive(1'b1, 32'hBFAF_0000, 32'h0000_000F);
        step();
        chk32("rst_led_wr_ignored", {16'h0, led}, 32'h0);
        reset = 1'b0;
        drive(1'b0, 32'h0000_0100, 32'h0);
        step();
        chk32("post_reset_ram", rdata, 32'hDEAD_BEEF);
        drive(1'b0, 32'hBFAF_0008, 32'h0);
        step();
        chk32("post_reset_scratch", rdata, 32'h0);
        drive(1'b0, 32'hBFAF_0000, 32'h0);
        step();
        chk32("post_reset_led_rd", rdata, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_sram_slave.md
# data_sram_slave

Responder for the CPU's data SRAM port: a synchronous word-wide memory plus a small memory-mapped register window, answering `io_data_sram_we/addr/wdata` and returning `io_data_sram_rdata` with one-cycle latency. It is instantiated beside `MYCPU_TOP` in the simulation/FPGA top and connects to the core's data SRAM port signal-for-signal. It serves as the bench's data memory and as the minimal MMIO target for LED and timer access.

## Interface
- `ADDR_WIDTH`, 14: word-address bits of the RAM (depth 2^ADDR_WIDTH words, 64 KiB at default).
- `MMIO_BASE`, 16'hBFAF: value of `addr[31:16]` selecting the MMIO window.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_data_sram_we`  in  1  write enable for the current access.
- `io_data_sram_addr`  in  32  byte address; `[1:0]` ignored.
- `io_data_sram_wdata`  in  32  write data.
- `io_data_sram_rdata`  out  32  read data, registered.
- `io_led`  out  16  LED register contents.
- `io_timer`  out  32  timer register contents (0 when timer compiled out).

## Operation
- Address decode, every cycle: MMIO if `addr[31:16] == MMIO_BASE`, else RAM.
- RAM index = `addr[ADDR_WIDTH+1:2]`; upper bits ignored, so out-of-range addresses alias (wrap modulo depth).
- Every cycle is an access; no idle or valid qualifier exists. A read occurs whenever `we=0`; the result lands in `io_data_sram_rdata`.
- RAM write (`we=1`): the full 32-bit word is written at the edge. Read-first semantics apply: `rdata` after that edge is the word's old value.
- MMIO offsets (`addr[15:0]`):
  - 0x0000 LED: reads `{16'b0, led}`; a write loads `wdata[15:0]`.
  - 0x0004 TIMER: reads the current count; a write loads `wdata`.
  - 0x0008 SCRATCH: 32-bit read/write register.
  - Any other offset reads 0; writes to it are ignored.
- MMIO writes also return the pre-write register value on `rdata` (read-first, consistent with RAM).
- Timer: free-running 32-bit up-counter, +1 per cycle, wraps 0xFFFFFFFF→0. A write has priority over the increment for that edge; counting resumes from the written value on the next edge.
- `rdata` mux select is registered together with the read. A RAM read and an MMIO read in back-to-back cycles return each target's data in its own cycle.

## Timing
- Read latency exactly 1: address presented in cycle N → `rdata` valid from the edge ending N, held through cycle N+1.
- Write latency: visible to a read issued in the next cycle (N+1 read returns the new data at N+2).
- Timer read returns the count sampled at the edge ending cycle N.
- Reset values: `io_data_sram_rdata`=0, `io_led`=0, `io_timer`=0, SCRATCH=0. RAM contents are not reset and are preserved across reset.
- Reset asserted mid-stream: any in-flight read result is discarded (`rdata`=0 on the cycle after reset). Writes presented while `reset=1` are ignored, both RAM and MMIO.
- First access after reset deassertion behaves normally; no warm-up cycle.

## Configuration
- `DATA_SRAM_SLAVE_TIMER_EN` defined: TIMER register and counter present as described; `io_timer` reflects the count.
- Not defined: no counter logic; offset 0x0004 behaves as unmapped (reads 0, writes ignored); `io_timer` tied to 0.

## Test plan
- Write 0xDEADBEEF to 0x0000_0100, read 0x0000_0100 next cycle → `rdata`=0xDEADBEEF one cycle after the read address.
- Write 0x1 to 0x0000_0040, then same cycle-pair write 0x2 with read-back check (`we=1`, same address) → `rdata`=0x1 (old value), subsequent read → 0x2.
- With ADDR_WIDTH=14: write 0x55 to 0x0001_0004, read 0x0000_0004 → 0x55 (alias).
- Write 0x00A5 to 0xBFAF_0000 → `io_led`=0x00A5 next cycle; read 0xBFAF_0000 → 0x0000_00A5; read 0xBFAF_0010 → 0.
- TIMER_EN: write 0xFFFFFFFE to 0xBFAF_0004 → `io_timer`=0xFFFFFFFE, 0xFFFFFFFF, 0x0 on three successive edges; without macro → reads 0 and `io_timer` stays 0.
- Assert `reset` for one cycle during back-to-back reads → `rdata`=0, `io_led`=0, `io_timer`=0 after reset; RAM word 0x100 still reads 0xDEADBEEF.
